// File: rtl/hazard_fwd_unit.sv
// Tag-only hazard and forwarding unit: tracks EX/MEM/WB destination tags
// and drives per-source forwarding selects, load-use stall and EX bubble.
module hazard_fwd_unit #(
  parameter int RW      = 4,
  parameter int NUM_SRC = 3,
  parameter int PC_REG  = 15,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_rf_e,
  input  logic                 id_load,
  input  logic [NUM_SRC*RW-1:0] id_src,
  input  logic [NUM_SRC-1:0]   id_src_use,
  input  logic                 flush,
  input  logic                 stat_clr,
  output logic [NUM_SRC*2-1:0] fwd_sel,
  output logic                 stall,
  output logic                 nop_ex,
  output logic [CNT_W-1:0]     stall_count
);

  typedef struct packed {
    logic          we;
    logic [RW-1:0] rd;
    logic          ld;
  } slot_t;

  localparam logic [RW-1:0] PC_IDX = RW'(PC_REG);

  slot_t ex_q, mem_q, wb_q;

  logic [NUM_SRC-1:0] live;
  logic [NUM_SRC-1:0] m_ex;
  logic [NUM_SRC-1:0] m_mem;
  logic [NUM_SRC-1:0] m_wb;
  logic               issue;

  // WB load flag is carried for completeness only
  logic unused_wb_ld;
  assign unused_wb_ld = wb_q.ld;

  always_comb begin
    live    = '0;
    m_ex    = '0;
    m_mem   = '0;
    m_wb    = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      live[i]  = id_src_use[i] &&
                 (id_src[i*RW +: RW] != PC_IDX);
      m_ex[i]  = live[i] && ex_q.we &&
                 (ex_q.rd == id_src[i*RW +: RW]);
      m_mem[i] = live[i] && mem_q.we &&
                 (mem_q.rd == id_src[i*RW +: RW]);
      m_wb[i]  = live[i] && wb_q.we &&
                 (wb_q.rd == id_src[i*RW +: RW]);
      if (m_ex[i])
        fwd_sel[i*2 +: 2] = 2'b01;
      else if (m_mem[i])
        fwd_sel[i*2 +: 2] = 2'b10;
      else if (m_wb[i])
        fwd_sel[i*2 +: 2] = 2'b11;
      else
        fwd_sel[i*2 +: 2] = 2'b00;
    end
  end

  assign stall  = id_valid & ~flush & ex_q.ld & (|m_ex);
  assign nop_ex = stall | flush;
  assign issue  = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue)
        ex_q <= {id_rf_e, id_rd, id_load};
      else
        ex_q <= '0;
      if (stat_clr)
        stall_count <= '0;
      else if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with a 2-bit stall counter
// so saturation is reachable in a handful of stalls.
module tb_hazard_fwd_unit;

  localparam int RW = 4;
  localparam int NS = 3;
  localparam int CW = 2;

  logic            clk;
  logic            reset;
  logic            id_valid;
  logic [RW-1:0]   id_rd;
  logic            id_rf_e;
  logic            id_load;
  logic [NS*RW-1:0] id_src;
  logic [NS-1:0]   id_src_use;
  logic            flush;
  logic            stat_clr;
  logic [NS*2-1:0] fwd_sel;
  logic            stall;
  logic            nop_ex;
  logic [CW-1:0]   stall_count;

  int checks = 0;
  int errors = 0;

  hazard_fwd_unit #(
    .RW(RW), .NUM_SRC(NS), .PC_REG(15), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rd(id_rd),
    .id_rf_e(id_rf_e),
    .id_load(id_load),
    .id_src(id_src),
    .id_src_use(id_src_use),
    .flush(flush),
    .stat_clr(stat_clr),
    .fwd_sel(fwd_sel),
    .stall(stall),
    .nop_ex(nop_ex),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [3:0] rd,
                       input logic we,
                       input logic ld,
                       input logic [3:0] s0,
                       input logic [3:0] s1,
                       input logic [3:0] s2,
                       input logic [2:0] use_m,
                       input logic fl);
    id_valid   = v;
    id_rd      = rd;
    id_rf_e    = we;
    id_load    = ld;
    id_src     = {s2, s1, s0};
    id_src_use = use_m;
    flush      = fl;
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    stat_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    #1;
    chk("rst_fwd", fwd_sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_nop", nop_ex, 0);
    chk("rst_cnt", stall_count, 0);
    flush = 1'b1;
    #1;
    chk("rst_nop_flush", nop_ex, 1);
    flush = 1'b0;
    #3;
    reset = 1'b1;
    tick();

    // ADD r1, then a reader of r1 ages through EX/MEM/WB
    drive(1, 1, 1, 0, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 5, 0, 0, 1, 0, 0, 3'b001, 0);
    chk("fwd_ex", fwd_sel, 6'b000001);
    chk("fwd_ex_stall", stall, 0);
    tick();
    chk("fwd_mem", fwd_sel, 6'b000010);
    tick();
    chk("fwd_wb", fwd_sel, 6'b000011);
    tick();
    chk("fwd_rf", fwd_sel, 6'b000000);

    // LDR r2 then ADD reading r2 on source 1
    drive(1, 2, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 6, 0, 0, 0, 2, 0, 3'b010, 0);
    chk("lu_stall", stall, 1);
    chk("lu_nop", nop_ex, 1);
    chk("lu_sel", fwd_sel, 6'b000100);
    tick();
    chk("lu_stall_gone", stall, 0);
    chk("lu_nop_gone", nop_ex, 0);
    chk("lu_sel_mem", fwd_sel, 6'b001000);
    chk("lu_cnt", stall_count, 1);
    tick();

    // ADD r3, SUB r3, then reader on source 2
    drive(1, 3, 1, 0, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 7, 0, 0, 0, 0, 3, 3'b100, 0);
    chk("young_wins", fwd_sel, 6'b010000);
    drive(1, 7, 0, 0, 0, 0, 3, 3'b000, 0);
    chk("unused_src", fwd_sel, 6'b000000);
    drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tick();
    tick();
    tick();

    // load into PC register never stalls or forwards
    drive(1, 15, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 8, 0, 0, 15, 0, 0, 3'b001, 0);
    chk("pc_stall", stall, 0);
    chk("pc_sel", fwd_sel, 6'b000000);
    tick();

    // load r4, dependent instruction flushed
    drive(1, 4, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 8, 1, 0, 4, 0, 0, 3'b001, 1);
    chk("flush_stall", stall, 0);
    chk("flush_nop", nop_ex, 1);
    tick();
    drive(1, 8, 0, 0, 4, 0, 0, 3'b001, 0);
    chk("flush_bubble_sel", fwd_sel, 6'b000010);
    chk("flush_bubble_stall", stall, 0);
    chk("flush_cnt", stall_count, 1);

    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_cnt", stall_count, 0);

    // saturation: 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      drive(1, 6, 1, 1, 0, 0, 0, 3'b000, 0);
      tick();
      drive(1, 9, 0, 0, 6, 0, 0, 3'b001, 0);
      chk("sat_stall", stall, 1);
      tick();
      chk($sformatf("sat_cnt%0d", k), stall_count,
          (k < 2) ? k + 1 : 3);
    end

    // clear wins over increment
    drive(1, 6, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 9, 0, 0, 6, 0, 0, 3'b001, 0);
    stat_clr = 1'b1;
    chk("clr_stall", stall, 1);
    tick();
    stat_clr = 1'b0;
    chk("clr_prio", stall_count, 0);

    // count one stall, then reset mid-stall
    drive(1, 7, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 9, 0, 0, 7, 0, 0, 3'b001, 0);
    tick();
    chk("pre_rst_cnt", stall_count, 1);
    drive(1, 7, 1, 1, 0, 0, 0, 3'b000, 0);
    tick();
    drive(1, 9, 0, 0, 7, 0, 0, 3'b001, 0);
    chk("pre_rst_stall", stall, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_cnt", stall_count, 0);
    chk("arst_sel", fwd_sel, 6'b000000);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_sel", fwd_sel, 6'b000000);
    chk("post_rst_stall", stall, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
